// File: rtl/bus_pkg.sv
// Shared types and helpers for the system bus arbiter and related scanners.
package bus_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, ERR} arb_state_t;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 32;

  // Width of an index that addresses n requesters (at least one bit).
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping modulo N.
module rr_pick
  import bus_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [N-1:0]  winner_oh,
  output logic [IW-1:0] winner
);

  logic [IW:0] cand;

  // One spare bit keeps last+k from overflowing before the explicit modulo.
  always_comb begin
    cand      = '0;
    valid     = 1'b0;
    winner    = '0;
    winner_oh = '0;
    for (int k = 1; k <= int'(N); k++) begin
      cand = {1'b0, last} + (IW + 1)'(k);
      if (cand >= (IW + 1)'(N)) cand = cand - (IW + 1)'(N);
      if (!valid && req[cand[IW-1:0]]) begin
        valid                 = 1'b1;
        winner                = cand[IW-1:0];
        winner_oh[cand[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system bus arbiter with cycle-locked grants and a no-ack watchdog.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NMASTER = 2,
  parameter int unsigned AW      = BUS_AW,
  parameter int unsigned DW      = BUS_DW,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NMASTER-1:0]      m_cyc_i,
  input  logic [NMASTER-1:0]      m_we_i,
  input  logic [NMASTER*AW-1:0]   m_adr_i,
  input  logic [NMASTER*DW/8-1:0] m_sel_i,
  input  logic [NMASTER*DW-1:0]   m_dat_i,
  output logic [DW-1:0]           m_dat_o,
  output logic [NMASTER-1:0]      m_ack_o,
  output logic [NMASTER-1:0]      m_err_o,
  output logic                    s_cyc_o,
  output logic                    s_we_o,
  output logic [AW-1:0]           s_adr_o,
  output logic [DW/8-1:0]         s_sel_o,
  output logic [DW-1:0]           s_dat_o,
  input  logic [DW-1:0]           s_dat_i,
  input  logic                    s_ack_i,
  output logic [NMASTER-1:0]      grant_o,
  output logic                    timeout_o
);

  localparam int unsigned IW = idx_width(NMASTER);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = DW / 8;

  arb_state_t         state_q, state_d;
  logic [IW-1:0]      gidx_q, gidx_d;
  logic [NMASTER-1:0] grant_q, grant_d;
  logic [IW-1:0]      last_q, last_d;
  logic [WW-1:0]      wd_q, wd_d;
  logic               tmo_q, tmo_d;

  logic               pick_valid;
  logic [NMASTER-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               cyc_g;

  rr_pick #(
    .N  (NMASTER),
    .IW (IW)
  ) u_pick (
    .req       (m_cyc_i),
    .last      (last_q),
    .valid     (pick_valid),
    .winner_oh (pick_oh),
    .winner    (pick_idx)
  );

  assign cyc_g     = m_cyc_i[gidx_q];
  assign grant_o   = grant_q;
  assign timeout_o = tmo_q;
  assign m_dat_o   = s_dat_i;

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = wd_q;
    tmo_d   = 1'b0;
    s_cyc_o = 1'b0;
    m_ack_o = '0;
    m_err_o = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          gidx_d  = pick_idx;
          grant_d = pick_oh;
          wd_d    = '0;
        end
      end
      BUSY: begin
        s_cyc_o = cyc_g;
        m_ack_o = grant_q & {NMASTER{s_ack_i}};
        if (!cyc_g) begin
          state_d = IDLE;
          last_d  = gidx_q;
          grant_d = '0;
        end else if (s_ack_i) begin
          // An ack on the threshold cycle still counts as progress.
          wd_d = '0;
        end else if (wd_q == WW'(TIMEOUT)) begin
          m_err_o = grant_q;
          tmo_d   = 1'b1;
          state_d = ERR;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      ERR: begin
        if (!cyc_g) begin
          state_d = IDLE;
          last_d  = gidx_q;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Master-side request fields reach the slaves only while a grant is held.
  always_comb begin
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_sel_o = '0;
    s_dat_o = '0;
    if (state_q != IDLE) begin
      s_we_o  = m_we_i[gidx_q];
      s_adr_o = m_adr_i[gidx_q*AW +: AW];
      s_sel_o = m_sel_i[gidx_q*SW +: SW];
      s_dat_o = m_dat_i[gidx_q*DW +: DW];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      gidx_q  <= '0;
      grant_q <= '0;
      last_q  <= IW'(NMASTER - 1);
      wd_q    <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule
